// File: rtl/game_over_banner_ctrl.sv
// -----------------------------------------------------------------------------
// game_over_banner_ctrl
//
// Spells the end-of-game banner "GAME OVER" one glyph at a time. For each of the
// nine slots (G A M E _ O V E R) it drives a letter index to an external
// combinational 5x5 decoder. It latches the returned glyph and shows it for
// HOLD_TICKS display ticks. When GAP_TICKS > 0 it inserts that many blank ticks
// between consecutive slots.
//
// Optional feature (macro BANNER_LOOP_EN):
//   defined   - the banner repeats until abort/rst; done pulses once per pass.
//   undefined - a single pass, then a one-cycle DONE state and back to IDLE.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   tick           one-cycle timebase enable from the frame divider
//   start          begin banner (honoured only in IDLE)
//   abort          cancel banner immediately (highest priority)
//   alphabet_order letter index to decoder (0=G 1=A 2=M 3=E 4=O 5=V 6=R)
//   display_code   25-bit glyph returned combinationally by the decoder
//   glyph          registered glyph to renderer, row-major, MSB = top-left
//   glyph_valid    glyph is a displayable slot (letter or space)
//   slot_idx       current slot 0..8
//   busy           high in every state except IDLE
//   done           one-cycle pulse at banner completion
// -----------------------------------------------------------------------------
module game_over_banner_ctrl #(
    parameter int HOLD_TICKS = 50,
    parameter int GAP_TICKS  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        abort,
    output logic [2:0]  alphabet_order,
    input  logic [24:0] display_code,
    output logic [24:0] glyph,
    output logic        glyph_valid,
    output logic [3:0]  slot_idx,
    output logic        busy,
    output logic        done
);

    localparam int MAX_HG   = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int MAX_T    = (MAX_HG > 2) ? MAX_HG : 2;
    localparam int CW       = $clog2(MAX_T);
    localparam bit GAP_EN   = (GAP_TICKS > 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [3:0] LAST_SLOT  = 4'd8;
    localparam logic [3:0] SPACE_SLOT = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW,
        S_GAP,
        S_DONE
    } state_t;

    // Letter index for each slot of "GAME OVER"; the space slot borrows index 0
    // and its glyph is forced blank when loaded.
    function automatic logic [2:0] slot_code(input logic [3:0] slot);
        case (slot)
            4'd0:    slot_code = 3'd0;
            4'd1:    slot_code = 3'd1;
            4'd2:    slot_code = 3'd2;
            4'd3:    slot_code = 3'd3;
            4'd5:    slot_code = 3'd4;
            4'd6:    slot_code = 3'd5;
            4'd7:    slot_code = 3'd3;
            4'd8:    slot_code = 3'd6;
            default: slot_code = 3'd0;
        endcase
    endfunction

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_n;
    logic [24:0]     glyph_n;
    logic            valid_n;
    logic [3:0]      slot_n;
    logic [2:0]      order_n;
    logic            busy_n;
    logic            done_n;

    logic            slot_end;
    logic            gap_end;
    logic            last_slot;
    logic [3:0]      slot_inc;

    assign slot_end  = (state == S_SHOW) && tick && (cnt == HOLD_LAST);
    assign gap_end   = (state == S_GAP)  && tick && (cnt == GAP_LAST);
    assign last_slot = (slot_idx == LAST_SLOT);
    // Wraps to slot 0 only in loop mode; single-pass mode never leaves slot 8
    // through this path.
    assign slot_inc  = last_slot ? 4'd0 : slot_idx + 4'd1;

    // State and output registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            glyph          <= '0;
            glyph_valid    <= 1'b0;
            slot_idx       <= 4'd0;
            alphabet_order <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_n;
            glyph          <= glyph_n;
            glyph_valid    <= valid_n;
            slot_idx       <= slot_n;
            alphabet_order <= order_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path assigned,
        // so no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_SHOW;
            S_SHOW: begin
                if (slot_end) begin
                    if (last_slot) begin
`ifdef BANNER_LOOP_EN
                        state_next = GAP_EN ? S_GAP : S_LOAD;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = GAP_EN ? S_GAP : S_LOAD;
                    end
                end
            end
            S_GAP:  if (gap_end) state_next = S_LOAD;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // abort wins over start and tick from any state.
        if (abort) state_next = S_IDLE;
    end

    // Output logic: computes the next value of every registered output.
    always_comb begin
        glyph_n = glyph;
        valid_n = glyph_valid;
        slot_n  = slot_idx;
        order_n = alphabet_order;
        busy_n  = (state_next != S_IDLE);
        // The pass completes on the ending tick of slot 8 in both modes.
        done_n  = slot_end && last_slot && !abort;

        // The counter restarts on every state change and never wraps inside a slot.
        if (state_next != state)
            cnt_n = '0;
        else if (tick && (state == S_SHOW || state == S_GAP))
            cnt_n = cnt + 1'b1;
        else
            cnt_n = cnt;

        // The decoder has had the whole LOAD cycle to settle on alphabet_order.
        if (state == S_LOAD) begin
            glyph_n = (slot_idx == SPACE_SLOT) ? 25'd0 : display_code;
            valid_n = 1'b1;
        end

        // The slot index and the decoder index advance together on entry to LOAD.
        if (state_next == S_LOAD && state != S_LOAD) begin
            slot_n  = (state == S_IDLE) ? 4'd0 : slot_inc;
            order_n = slot_code(slot_n);
        end

        if ((state_next == S_GAP && state != S_GAP) || state_next == S_DONE) begin
            glyph_n = '0;
            valid_n = 1'b0;
        end

        if (state_next == S_IDLE) begin
            glyph_n = '0;
            valid_n = 1'b0;
            slot_n  = 4'd0;
            order_n = 3'd0;
        end
    end

endmodule
